hazard_stall_ctrl: RTL and testbench

//  Pipeline hazard and stall controller for the 5-stage MIPS core.
//  - Compares D-stage source registers against E/M destinations using Tuse/Tnew.
//  - Sequences the HI/LO multiply/divide busy window.
//  - Drives the write enables of PC and the F/D register, plus the bubble (clear) into the D/E register.
//  - Keeps a saturating stall-cycle counter and a sticky protocol-error flag.

---
 rtl/hazard_stall_ctrl.sv | 113 +++++++++++
 tb/tb_hazard_stall_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// Hazard and stall controller for the 5-stage MIPS pipeline: Tuse/Tnew operand
// checks, HI/LO multiply/divide busy window, stall counter and protocol-error flag.
module hazard_stall_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rs_D,
  input  logic [4:0]       rt_D,
  input  logic [1:0]       tuse_rs_D,
  input  logic [1:0]       tuse_rt_D,
  input  logic [4:0]       wa_E,
  input  logic [1:0]       tnew_E,
  input  logic [4:0]       wa_M,
  input  logic [1:0]       tnew_M,
  input  logic             md_D,
  input  logic             start_E,
  input  logic             is_div_E,
  output logic             PC_WE,
  output logic             F_D_WE,
  output logic             D_E_WE,
  output logic             D_E_clr,
  output logic             busy,
  output logic [CNT_W-1:0] md_cnt,
  output logic [31:0]      stall_cnt,
  output logic             md_err
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} md_state_e;

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [31:0]      STALL_MAX = 32'hFFFF_FFFF;

  md_state_e        state_q = IDLE;
  logic [CNT_W-1:0] md_cnt_q = '0;
  logic             md_err_q = 1'b0;
  logic [31:0]      stall_cnt_q = '0;

  md_state_e        state_d;
  logic [CNT_W-1:0] md_cnt_d;
  logic             md_err_d;
  logic [31:0]      stall_cnt_d;

  // Index 0 is rs, index 1 is rt; both sources use the identical Tuse/Tnew rule.
  logic [1:0][4:0] src_D;
  logic [1:0][1:0] tuse_D;
  logic [1:0]      src_stall;
  logic            stall_md;
  logic            stall;

  assign src_D  = {rt_D, rs_D};
  assign tuse_D = {tuse_rt_D, tuse_rs_D};

  for (genvar gi = 0; gi < 2; gi++) begin : g_src
    assign src_stall[gi] = (tuse_D[gi] != 2'd3) && (src_D[gi] != 5'd0) &&
                           (((src_D[gi] == wa_E) && (tnew_E > tuse_D[gi])) ||
                            ((src_D[gi] == wa_M) && (tnew_M > tuse_D[gi])));
  end

  assign stall_md = md_D && ((state_q == BUSY) || start_E);
  assign stall    = (|src_stall) | stall_md;

  assign PC_WE     = ~stall;
  assign F_D_WE    = ~stall;
  assign D_E_WE    = 1'b1;
  assign D_E_clr   = stall;
  assign busy      = (state_q == BUSY);
  assign md_cnt    = md_cnt_q;
  assign md_err    = md_err_q;
  assign stall_cnt = stall_cnt_q;

  always_comb begin
    state_d     = state_q;
    md_cnt_d    = md_cnt_q;
    md_err_d    = md_err_q;
    stall_cnt_d = stall_cnt_q;
    if (state_q == IDLE) begin
      if (start_E) begin
        state_d  = BUSY;
        md_cnt_d = is_div_E ? DIV_LOAD : MULT_LOAD;
      end
    end else begin
      // A second start while occupied is flagged but never restarts the window.
      if (start_E) md_err_d = 1'b1;
      if (md_cnt_q == CNT_ONE) begin
        state_d  = IDLE;
        md_cnt_d = '0;
      end else begin
        md_cnt_d = md_cnt_q - CNT_ONE;
      end
    end
    if (stall && (stall_cnt_q != STALL_MAX)) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      md_cnt_q    <= '0;
      md_err_q    <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      md_cnt_q    <= md_cnt_d;
      md_err_q    <= md_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed scenarios plus randomized
// traffic against a cycle-count reference model.
module tb_hazard_stall_ctrl;
  localparam longint unsigned SMAX = 64'h0000_0000_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  rs_D, rt_D, wa_E, wa_M;
  logic [1:0]  tuse_rs_D, tuse_rt_D, tnew_E, tnew_M;
  logic        md_D, start_E, is_div_E;
  logic        PC_WE, F_D_WE, D_E_WE, D_E_clr, busy, md_err;
  logic [3:0]  md_cnt;
  logic [31:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: cycles left in the HI/LO window, error flag, stall total.
  int              m_left = 0;
  bit              m_err = 1'b0;
  longint unsigned m_scnt = 0;

  always #5 clk = ~clk;

  hazard_stall_ctrl dut (
    .clk(clk), .reset(reset),
    .rs_D(rs_D), .rt_D(rt_D), .tuse_rs_D(tuse_rs_D), .tuse_rt_D(tuse_rt_D),
    .wa_E(wa_E), .tnew_E(tnew_E), .wa_M(wa_M), .tnew_M(tnew_M),
    .md_D(md_D), .start_E(start_E), .is_div_E(is_div_E),
    .PC_WE(PC_WE), .F_D_WE(F_D_WE), .D_E_WE(D_E_WE), .D_E_clr(D_E_clr),
    .busy(busy), .md_cnt(md_cnt), .stall_cnt(stall_cnt), .md_err(md_err)
  );

  // A source waits while the producer needs more cycles than the consumer can wait.
  function automatic bit src_waits(logic [4:0] r, logic [1:0] tu);
    int need_in = int'(tu);
    if (tu == 2'd3 || r == 5'd0) return 1'b0;
    if (r == wa_E && int'(tnew_E) > need_in) return 1'b1;
    if (r == wa_M && int'(tnew_M) > need_in) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit exp_stall();
    return src_waits(rs_D, tuse_rs_D) || src_waits(rt_D, tuse_rt_D) ||
           (md_D && (m_left > 0 || start_E));
  endfunction

  task automatic clear_inputs();
    rs_D = 5'd0; rt_D = 5'd0; tuse_rs_D = 2'd3; tuse_rt_D = 2'd3;
    wa_E = 5'd0; tnew_E = 2'd0; wa_M = 5'd0; tnew_M = 2'd0;
    md_D = 1'b0; start_E = 1'b0; is_div_E = 1'b0;
  endtask

  // Advance one clock edge, updating the model from the inputs held at that edge.
  task automatic tick();
    int nl = m_left;
    bit ne = m_err;
    longint unsigned ns = m_scnt;
    if (!reset) begin
      nl = 0; ne = 1'b0; ns = 0;
    end else begin
      if (exp_stall()) ns = (m_scnt == SMAX) ? SMAX : m_scnt + 1;
      if (m_left > 0) begin
        nl = m_left - 1;
        if (start_E) ne = 1'b1;
      end else if (start_E) begin
        nl = is_div_E ? 10 : 5;
      end
    end
    @(posedge clk);
    m_left = nl; m_err = ne; m_scnt = ns;
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    #1;
    checks++; if (busy !== 1'b0 || md_cnt !== 4'd0 || stall_cnt !== 32'd0 || md_err !== 1'b0) begin
      errors++; $display("FAIL init_state: busy=%b md_cnt=%0d stall_cnt=%0d md_err=%b, want 0/0/0/0", busy, md_cnt, stall_cnt, md_err);
    end
    do_reset();
    #1;
    checks++; if (busy !== 1'b0 || md_cnt !== 4'd0 || stall_cnt !== 32'd0 || md_err !== 1'b0) begin
      errors++; $display("FAIL reset_state: busy=%b md_cnt=%0d stall_cnt=%0d md_err=%b, want 0/0/0/0", busy, md_cnt, stall_cnt, md_err);
    end
    checks++; if (PC_WE !== 1'b1 || F_D_WE !== 1'b1 || D_E_clr !== 1'b0 || D_E_WE !== 1'b1) begin
      errors++; $display("FAIL reset_enables: PC_WE=%b F_D_WE=%b D_E_clr=%b D_E_WE=%b, want 1/1/0/1", PC_WE, F_D_WE, D_E_clr, D_E_WE);
    end
    $display("test_reset done");
  endtask

  task automatic test_load_use();
    clear_inputs();
    rs_D = 5'd8; tuse_rs_D = 2'd0; wa_E = 5'd8; tnew_E = 2'd2;
    #1;
    checks++; if (PC_WE !== 1'b0 || F_D_WE !== 1'b0 || D_E_clr !== 1'b1 || D_E_WE !== 1'b1) begin
      errors++; $display("FAIL load_use_stall: PC_WE=%b F_D_WE=%b D_E_clr=%b D_E_WE=%b, want 0/0/1/1", PC_WE, F_D_WE, D_E_clr, D_E_WE);
    end
    tick();
    clear_inputs();
    rs_D = 5'd8; tuse_rs_D = 2'd1; wa_M = 5'd8; tnew_M = 2'd1;
    #1;
    checks++; if (PC_WE !== 1'b1 || D_E_clr !== 1'b0) begin
      errors++; $display("FAIL m_forward_equal: PC_WE=%b D_E_clr=%b, want 1/0", PC_WE, D_E_clr);
    end
    tick();
    clear_inputs();
    rt_D = 5'd9; tuse_rt_D = 2'd1; wa_M = 5'd9; tnew_M = 2'd2;
    #1;
    checks++; if (PC_WE !== 1'b0 || D_E_clr !== 1'b1) begin
      errors++; $display("FAIL rt_m_stall: PC_WE=%b D_E_clr=%b, want 0/1", PC_WE, D_E_clr);
    end
    tick();
    $display("test_load_use done");
  endtask

  task automatic test_reg0_tuse3();
    clear_inputs();
    rs_D = 5'd0; tuse_rs_D = 2'd0; wa_E = 5'd0; tnew_E = 2'd2;
    #1;
    checks++; if (PC_WE !== 1'b1 || D_E_clr !== 1'b0) begin
      errors++; $display("FAIL reg0_no_stall: PC_WE=%b D_E_clr=%b, want 1/0", PC_WE, D_E_clr);
    end
    tick();
    clear_inputs();
    rt_D = 5'd12; tuse_rt_D = 2'd3; wa_E = 5'd12; tnew_E = 2'd2;
    #1;
    checks++; if (PC_WE !== 1'b1 || D_E_clr !== 1'b0) begin
      errors++; $display("FAIL tuse3_no_stall: PC_WE=%b D_E_clr=%b, want 1/0", PC_WE, D_E_clr);
    end
    tick();
    $display("test_reg0_tuse3 done");
  endtask

  task automatic test_mult_window();
    do_reset();
    clear_inputs();
    start_E = 1'b1; is_div_E = 1'b0; md_D = 1'b1;
    #1;
    checks++; if (PC_WE !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL mult_t0: PC_WE=%b busy=%b, want 0/0", PC_WE, busy);
    end
    tick();
    start_E = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      #1;
      checks++; if (busy !== 1'b1 || md_cnt !== 4'(6 - k) || PC_WE !== 1'b0) begin
        errors++; $display("FAIL mult_window k=%0d: busy=%b md_cnt=%0d PC_WE=%b, want 1/%0d/0", k, busy, md_cnt, PC_WE, 6 - k);
      end
      tick();
    end
    #1;
    checks++; if (busy !== 1'b0 || md_cnt !== 4'd0 || PC_WE !== 1'b1 || md_err !== 1'b0) begin
      errors++; $display("FAIL mult_release: busy=%b md_cnt=%0d PC_WE=%b md_err=%b, want 0/0/1/0", busy, md_cnt, PC_WE, md_err);
    end
    checks++; if (stall_cnt !== 32'd6) begin
      errors++; $display("FAIL mult_stall_cnt: got %0d want 6", stall_cnt);
    end
    tick();
    $display("test_mult_window done");
  endtask

  task automatic test_div_err();
    do_reset();
    clear_inputs();
    start_E = 1'b1; is_div_E = 1'b1;
    tick();
    start_E = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      start_E = (k == 3);
      #1;
      checks++; if (busy !== 1'b1 || md_cnt !== 4'(11 - k)) begin
        errors++; $display("FAIL div_window k=%0d: busy=%b md_cnt=%0d, want 1/%0d", k, busy, md_cnt, 11 - k);
      end
      tick();
    end
    start_E = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || md_cnt !== 4'd0 || md_err !== 1'b1) begin
      errors++; $display("FAIL div_end: busy=%b md_cnt=%0d md_err=%b, want 0/0/1", busy, md_cnt, md_err);
    end
    tick(); tick();
    checks++; if (md_err !== 1'b1) begin
      errors++; $display("FAIL md_err_sticky: got %b want 1", md_err);
    end
    $display("test_div_err done");
  endtask

  task automatic test_reset_mid_busy();
    do_reset();
    clear_inputs();
    start_E = 1'b1; md_D = 1'b1;
    tick();
    tick();
    start_E = 1'b0;
    #1;
    checks++; if (md_cnt !== 4'd4 || md_err !== 1'b1 || stall_cnt !== 32'd2) begin
      errors++; $display("FAIL pre_reset: md_cnt=%0d md_err=%b stall_cnt=%0d, want 4/1/2", md_cnt, md_err, stall_cnt);
    end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    md_D = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || md_cnt !== 4'd0 || stall_cnt !== 32'd0 || md_err !== 1'b0) begin
      errors++; $display("FAIL reset_abort: busy=%b md_cnt=%0d stall_cnt=%0d md_err=%b, want 0/0/0/0", busy, md_cnt, stall_cnt, md_err);
    end
    tick();
    $display("test_reset_mid_busy done");
  endtask

  task automatic test_stall_count_sat();
    do_reset();
    clear_inputs();
    rs_D = 5'd5; tuse_rs_D = 2'd0; wa_E = 5'd5; tnew_E = 2'd2;
    for (int k = 0; k < 7; k++) tick();
    checks++; if (stall_cnt !== 32'd7) begin
      errors++; $display("FAIL stall_cnt_7: got %0d want 7", stall_cnt);
    end
    force dut.stall_cnt_q = 32'hFFFF_FFFD;
    #1;
    release dut.stall_cnt_q;
    m_scnt = 64'h0000_0000_FFFF_FFFD;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (stall_cnt !== 32'(m_scnt)) begin
        errors++; $display("FAIL stall_sat k=%0d: got %h want %h", k, stall_cnt, 32'(m_scnt));
      end
    end
    checks++; if (stall_cnt !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL stall_sat_final: got %h want ffffffff", stall_cnt);
    end
    $display("test_stall_count_sat done");
  endtask

  task automatic test_random();
    bit es;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      rs_D = 5'($urandom_range(0, 3)); rt_D = 5'($urandom_range(0, 3));
      wa_E = 5'($urandom_range(0, 3)); wa_M = 5'($urandom_range(0, 3));
      tuse_rs_D = 2'($urandom_range(0, 3)); tuse_rt_D = 2'($urandom_range(0, 3));
      tnew_E = 2'($urandom_range(0, 3)); tnew_M = 2'($urandom_range(0, 3));
      md_D = ($urandom_range(0, 3) == 0);
      start_E = ($urandom_range(0, 9) == 0);
      is_div_E = $urandom_range(0, 1) == 1;
      reset = ($urandom_range(0, 49) != 0);
      #1;
      es = exp_stall();
      checks++; if (PC_WE !== ~es || F_D_WE !== ~es || D_E_clr !== es || D_E_WE !== 1'b1) begin
        errors++; $display("FAIL rand_stall n=%0d: PC_WE=%b F_D_WE=%b D_E_clr=%b D_E_WE=%b, want stall=%b", n, PC_WE, F_D_WE, D_E_clr, D_E_WE, es);
      end
      checks++; if (busy !== (m_left > 0) || md_cnt !== 4'(m_left) || md_err !== m_err || stall_cnt !== 32'(m_scnt)) begin
        errors++; $display("FAIL rand_state n=%0d: busy=%b md_cnt=%0d md_err=%b stall_cnt=%0d, want %b/%0d/%b/%0d", n, busy, md_cnt, md_err, stall_cnt, m_left > 0, m_left, m_err, m_scnt);
      end
      tick();
    end
    reset = 1'b1;
    $display("test_random done");
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_reg0_tuse3();
    test_mult_window();
    test_div_err();
    test_reset_mid_busy();
    test_stall_count_sat();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
